// File: rtl/online_test_pkg.sv
//----------------------------------------------------------------------------
// Module  : online_test_pkg
// Brief   : Shared widths and FSM state type for the online-test result path
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

package online_test_pkg;

    localparam int RES_W         = 11;
    localparam int NIB_W         = 4;
    localparam int NIBS_PER_WORD = 3;
    localparam int WORD_W        = NIB_W * NIBS_PER_WORD;

    // Serializer states; the NIBn name gives the nibble index being presented
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NIB2 = 2'd1,
        NIB1 = 2'd2,
        NIB0 = 2'd3
    } ser_state_t;

endpackage

`default_nettype wire

// File: rtl/result_fifo.sv
//----------------------------------------------------------------------------
// Module  : result_fifo
// Brief   : Synchronous FIFO with combinational head read and word count
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module result_fifo
    import online_test_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4,
    parameter int W     = RES_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     din,
    output logic [W-1:0]     dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign dout  = r_mem[r_rd_ptr];
    assign full  = (r_count == CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/online_result_serializer.sv
//----------------------------------------------------------------------------
// Module  : online_result_serializer
// Brief   : Buffers 11-bit results and emits each as three 4-bit nibbles,
//           MSB first, over valid/ready; sticky flag on dropped words
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module online_result_serializer
    import online_test_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RES_W-1:0] din,
    input  logic             din_valid,
    output logic [NIB_W-1:0] out_nib,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic [CNT_W-1:0] fifo_cnt,
    output logic             ovf
);

    ser_state_t        r_state;
    ser_state_t        w_state_nxt;
    logic [WORD_W-1:0] r_sr;
    logic              r_ovf;

    logic              w_pop;
    logic              w_push;
    logic              w_full;
    logic              w_empty;
    logic [RES_W-1:0]  w_head;

    // A push into a full FIFO is still accepted when a pop frees a slot
    assign w_push = din_valid && (!w_full || w_pop);

    result_fifo #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W),
        .W     (RES_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (din),
        .dout  (w_head),
        .full  (w_full),
        .empty (w_empty),
        .count (fifo_cnt)
    );

    // Next-state and pop decode; popping from NIB0 chains words with no bubble
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = NIB2;
                end
            end
            NIB2: begin
                if (out_ready) begin
                    w_state_nxt = NIB1;
                end
            end
            NIB1: begin
                if (out_ready) begin
                    w_state_nxt = NIB0;
                end
            end
            NIB0: begin
                if (out_ready) begin
                    if (!w_empty) begin
                        w_pop       = 1'b1;
                        w_state_nxt = NIB2;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register and shift register load on every pop
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_sr    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_pop) begin
                r_sr <= {{(WORD_W - RES_W){1'b0}}, w_head};
            end
        end
    end

    // Sticky overflow: a word arrived with the FIFO full and no slot freed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (din_valid && w_full && !w_pop) begin
            r_ovf <= 1'b1;
        end
    end

    // Outputs decoded from registered state and shift register only
    always_comb begin
        out_nib   = '0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        unique case (r_state)
            NIB2: begin
                out_valid = 1'b1;
                out_nib   = r_sr[11:8];
            end
            NIB1: begin
                out_valid = 1'b1;
                out_nib   = r_sr[7:4];
            end
            NIB0: begin
                out_valid = 1'b1;
                out_nib   = r_sr[3:0];
                out_last  = 1'b1;
            end
            default: begin
                out_valid = 1'b0;
            end
        endcase
    end

    assign ovf = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_online_result_serializer.sv
//----------------------------------------------------------------------------
// Module  : tb_online_result_serializer
// Brief   : Directed and random checks against a queue-based reference model
// Revision: 1.0 - initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_online_result_serializer;

    localparam int DEPTH = 8;
    localparam int CNT_W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [10:0] din = '0;
    logic        din_valid = 1'b0;
    logic [3:0]  out_nib;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_last;
    logic [CNT_W-1:0] fifo_cnt;
    logic        ovf;

    online_result_serializer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .out_nib   (out_nib),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .fifo_cnt  (fifo_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference model: a word being sent (with nibble index 0..2) plus a queue
    int unsigned m_q[$];
    bit          m_busy;
    int unsigned m_word;
    int          m_idx;
    bit          m_ovf;
    bit          m_armed;

    int n_vec;
    int n_err;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the model across one clock edge using the inputs applied
    task automatic model_edge(input bit r, input bit dv, input int unsigned d, input bit rdy);
        bit pop;
        if (r) begin
            m_q.delete();
            m_busy  = 0;
            m_word  = 0;
            m_idx   = 0;
            m_ovf   = 0;
            m_armed = 1;
            return;
        end
        pop = (m_q.size() > 0) && (!m_busy || (m_idx == 2 && rdy));
        if (m_busy && rdy) begin
            if (m_idx < 2) m_idx++;
            else m_busy = 0;
        end
        if (pop) begin
            m_word = m_q.pop_front();
            m_busy = 1;
            m_idx  = 0;
        end
        if (dv) begin
            if (m_q.size() < DEPTH) m_q.push_back(d);
            else m_ovf = 1;
        end
    endtask

    // One cycle: compare outputs at the falling edge, then drive and clock
    task automatic step(input bit r, input bit dv, input int unsigned d, input bit rdy);
        @(negedge clk);
        if (m_armed) begin
            check_eq("out_valid", out_valid, m_busy);
            check_eq("out_nib", out_nib, m_busy ? ((m_word >> (4 * (2 - m_idx))) & 4'hF) : 0);
            check_eq("out_last", out_last, m_busy && m_idx == 2);
            check_eq("fifo_cnt", fifo_cnt, m_q.size());
            check_eq("ovf", ovf, m_ovf);
        end
        rst       = r;
        din_valid = dv;
        din       = 11'(d);
        out_ready = rdy;
        @(posedge clk);
        model_edge(r, dv, d, rdy);
    endtask

    initial begin
        int unsigned bp_words [3];
        int rdy_pct;
        int dv_pct;
        n_vec   = 0;
        n_err   = 0;
        m_armed = 0;
        bp_words = '{32'h7FF, 32'h001, 32'h400};

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);

        // Single word with the consumer always ready
        step(0, 1, 32'h5A3, 1);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Three back-to-back words stream out with no bubble
        for (int i = 0; i < 3; i++) step(0, 1, bp_words[i], 1);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

        // Backpressure holds the first nibble stable
        step(0, 1, 32'h123, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        // Overflow: ten words into a stalled consumer, the last one dropped
        for (int i = 1; i <= 10; i++) step(0, 1, i, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        // Full FIFO with a pop in the same cycle as a new word
        step(0, 1, 32'h3C5, 1);
        step(0, 0, 0, 0);
        for (int i = 0; i < 35; i++) step(0, 0, 0, 1);

        // Reset in the middle of a word with several words queued
        for (int i = 0; i < 4; i++) step(0, 1, 32'h100 + i, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        step(0, 1, 32'h2B7, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

        // Random traffic with varying load and stall rates, rare resets
        for (int blk = 0; blk < 12; blk++) begin
            rdy_pct = $urandom_range(10, 100);
            dv_pct  = $urandom_range(10, 90);
            for (int i = 0; i < 250; i++) begin
                step(($urandom_range(0, 499) == 0),
                     ($urandom_range(0, 99) < dv_pct),
                     $urandom_range(0, 2047),
                     ($urandom_range(0, 99) < rdy_pct));
            end
        end
        step(0, 0, 0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
